// File: rtl/sparc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparc_mem_pkg
// Description : Shared opcode constants, size/state enums and MEM/WB record.
// Revision    : 1.0 - initial release
// ============================================================================
package sparc_mem_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b11;
    localparam logic [2:0] OP2_NOP = 3'b100;
    localparam logic [5:0] OP3_STX = 6'b001110;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [63:0] alures;
        logic [63:0] load_data;
        logic [4:0]  regd;
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic        reg_write;
        logic        reg_write_double;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '{
        alures:           64'd0,
        load_data:        64'd0,
        regd:             5'd0,
        op:               OP_NOP,
        op2:              OP2_NOP,
        op3:              6'd0,
        reg_write:        1'b0,
        reg_write_double: 1'b0
    };

    // STX shares the low op3 bits with a halfword access, so it is special-cased.
    function automatic mem_size_t decode_size(input logic [5:0] op3);
        mem_size_t size;
        if (op3 == OP3_STX) begin
            size = SIZE_DWORD;
        end else begin
            case (op3[1:0])
                2'b01:   size = SIZE_BYTE;
                2'b10:   size = SIZE_HALF;
                2'b00:   size = SIZE_WORD;
                default: size = SIZE_DWORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_t size);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = |addr_lo[1:0];
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_ext
// Description : Zero/sign extension of right-aligned load data to 64 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_ext
    import sparc_mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  mem_size_t   size,
    input  logic        sign_ext,
    output logic [63:0] data
);

    always_comb begin
        data = rdata;
        case (size)
            SIZE_BYTE: data = {{56{sign_ext & rdata[7]}},  rdata[7:0]};
            SIZE_HALF: data = {{48{sign_ext & rdata[15]}}, rdata[15:0]};
            SIZE_WORD: data = {{32{sign_ext & rdata[31]}}, rdata[31:0]};
            default:   data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage: MEM/WB register plus req/ack data-memory FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import sparc_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_valid_in,
    input  logic [63:0] MEM_alures_in,
    input  logic [63:0] MEM_store_data_in,
    input  logic [4:0]  MEM_regD_in,
    input  logic [1:0]  MEM_op_in,
    input  logic [2:0]  MEM_op2_in,
    input  logic [5:0]  MEM_op3_in,
    input  logic        MEM_regWrite_in,
    input  logic        MEM_regWriteDouble_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [1:0]  dmem_size,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        MEM_stall,
    output logic        MEM_trap_out,
    output logic [63:0] WB_alures_out,
    output logic [63:0] WB_load_data_out,
    output logic [4:0]  WB_regD_out,
    output logic [1:0]  WB_op_out,
    output logic [2:0]  WB_op2_out,
    output logic [5:0]  WB_op3_out,
    output logic        WB_regWrite_out,
    output logic        WB_regWriteDouble_out
);

    mem_state_t  r_state;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    mem_size_t   r_size;
    logic        r_sign;
    logic        r_trap;
    memwb_t      r_pend;
    memwb_t      r_memwb;

    logic        w_is_mem;
    logic        w_store;
    logic        w_misaligned;
    mem_size_t   w_size;
    logic [63:0] w_ext;

    assign w_is_mem     = MEM_valid_in && (MEM_op_in == OP_MEM);
    assign w_store      = MEM_op3_in[2];
    assign w_size       = decode_size(MEM_op3_in);
    assign w_misaligned = is_misaligned(MEM_alures_in[2:0], w_size);

    mem_load_ext u_load_ext (
        .rdata    (dmem_rdata),
        .size     (r_size),
        .sign_ext (r_sign),
        .data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_size  <= SIZE_BYTE;
            r_sign  <= 1'b0;
            r_trap  <= 1'b0;
            r_pend  <= MEMWB_BUBBLE;
            r_memwb <= MEMWB_BUBBLE;
        end else begin
            r_trap  <= 1'b0;
            r_memwb <= MEMWB_BUBBLE;
            case (r_state)
                IDLE: begin
                    if (MEM_valid_in && !w_is_mem) begin
                        r_memwb <= '{
                            alures:           MEM_alures_in,
                            load_data:        64'd0,
                            regd:             MEM_regD_in,
                            op:               MEM_op_in,
                            op2:              MEM_op2_in,
                            op3:              MEM_op3_in,
                            reg_write:        MEM_regWrite_in,
                            reg_write_double: MEM_regWriteDouble_in
                        };
                    end else if (w_is_mem && w_misaligned) begin
                        r_trap <= 1'b1;
                    end else if (w_is_mem) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= MEM_alures_in;
                        r_wdata <= MEM_store_data_in;
                        r_size  <= w_size;
                        r_sign  <= MEM_op3_in[3] && (w_size != SIZE_DWORD);
                        // Stores never write the register file.
                        r_pend  <= '{
                            alures:           MEM_alures_in,
                            load_data:        64'd0,
                            regd:             MEM_regD_in,
                            op:               MEM_op_in,
                            op2:              MEM_op2_in,
                            op3:              MEM_op3_in,
                            reg_write:        MEM_regWrite_in && !w_store,
                            reg_write_double: MEM_regWriteDouble_in && !w_store
                        };
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        r_state           <= IDLE;
                        r_req             <= 1'b0;
                        r_we              <= 1'b0;
                        r_memwb           <= r_pend;
                        r_memwb.load_data <= w_ext;
                    end
                end
            endcase
        end
    end

    assign MEM_stall = !reset &&
                       (((r_state == IDLE) && w_is_mem && !w_misaligned) ||
                        ((r_state == WAIT) && !dmem_ack));

    assign dmem_req              = r_req;
    assign dmem_we               = r_we;
    assign dmem_addr             = r_addr;
    assign dmem_wdata            = r_wdata;
    assign dmem_size             = r_size;
    assign MEM_trap_out          = r_trap;
    assign WB_alures_out         = r_memwb.alures;
    assign WB_load_data_out      = r_memwb.load_data;
    assign WB_regD_out           = r_memwb.regd;
    assign WB_op_out             = r_memwb.op;
    assign WB_op2_out            = r_memwb.op2;
    assign WB_op3_out            = r_memwb.op3;
    assign WB_regWrite_out       = r_memwb.reg_write;
    assign WB_regWriteDouble_out = r_memwb.reg_write_double;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage with a WB scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import sparc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [63:0] alures;
    logic [63:0] sdata;
    logic [4:0]  regd;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic        rw;
    logic        rwd;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [1:0]  dmem_size;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        stall;
    logic        trap;
    logic [63:0] wb_alures;
    logic [63:0] wb_load;
    logic [4:0]  wb_regd;
    logic [1:0]  wb_op;
    logic [2:0]  wb_op2;
    logic [5:0]  wb_op3;
    logic        wb_rw;
    logic        wb_rwd;

    int     n_cmp = 0;
    int     n_mis = 0;
    memwb_t sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .MEM_valid_in          (valid),
        .MEM_alures_in         (alures),
        .MEM_store_data_in     (sdata),
        .MEM_regD_in           (regd),
        .MEM_op_in             (op),
        .MEM_op2_in            (op2),
        .MEM_op3_in            (op3),
        .MEM_regWrite_in       (rw),
        .MEM_regWriteDouble_in (rwd),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_size             (dmem_size),
        .dmem_ack              (dmem_ack),
        .dmem_rdata            (dmem_rdata),
        .MEM_stall             (stall),
        .MEM_trap_out          (trap),
        .WB_alures_out         (wb_alures),
        .WB_load_data_out      (wb_load),
        .WB_regD_out           (wb_regd),
        .WB_op_out             (wb_op),
        .WB_op2_out            (wb_op2),
        .WB_op3_out            (wb_op3),
        .WB_regWrite_out       (wb_rw),
        .WB_regWriteDouble_out (wb_rwd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input memwb_t obs, input memwb_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Any non-bubble WB record must match the oldest expected entry.
    task automatic wb_check();
        memwb_t obs;
        obs = '{alures: wb_alures, load_data: wb_load, regd: wb_regd, op: wb_op,
                op2: wb_op2, op3: wb_op3, reg_write: wb_rw, reg_write_double: wb_rwd};
        if (wb_op !== OP_NOP) begin
            if (sb.size() == 0) chk_wb("wb_unexpected", obs, MEMWB_BUBBLE);
            else                chk_wb("wb_result", obs, sb.pop_front());
        end else begin
            chk_wb("wb_bubble", obs, MEMWB_BUBBLE);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wb_check();
    endtask

    task automatic drive(input logic [1:0] o, input logic [5:0] o3, input logic [63:0] a,
                         input logic [63:0] d, input logic [4:0] rd, input logic w, input logic wd);
        valid = 1'b1; op = o; op2 = 3'b000; op3 = o3; alures = a; sdata = d;
        regd = rd; rw = w; rwd = wd;
    endtask

    task automatic idle_in();
        valid = 1'b0; op = 2'b00; op2 = 3'b000; op3 = 6'd0; alures = 64'd0; sdata = 64'd0;
        regd = 5'd0; rw = 1'b0; rwd = 1'b0;
    endtask

    function automatic memwb_t rec(input logic [1:0] o, input logic [5:0] o3, input logic [63:0] a,
                                   input logic [63:0] ld, input logic [4:0] rd,
                                   input logic w, input logic wd);
        return '{alures: a, load_data: ld, regd: rd, op: o, op2: 3'b000, op3: o3,
                 reg_write: w, reg_write_double: wd};
    endfunction

    initial begin
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 64'd0;
        drive(2'b11, 6'b000010, 64'h10, 64'd0, 5'd1, 1'b1, 1'b0);
        #1;
        chk("stall_in_reset", {63'd0, stall}, 64'd0);
        tick();
        tick();
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_size", {62'd0, dmem_size}, 64'd0);
        chk("rst_trap", {63'd0, trap}, 64'd0);
        reset = 1'b0;
        idle_in();
        tick();

        // ADD: one-cycle pass-through
        drive(2'b10, 6'b000000, 64'h1234, 64'd0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("add_stall", {63'd0, stall}, 64'd0);
        sb.push_back(rec(2'b10, 6'b000000, 64'h1234, 64'd0, 5'd5, 1'b1, 1'b0));
        tick();
        chk("add_drained", sb.size(), 64'd0);
        idle_in();

        // LDSB at 0x1003, ack on the third WAIT cycle
        drive(2'b11, 6'b001001, 64'h1003, 64'd0, 5'd7, 1'b1, 1'b0);
        #1;
        chk("ldsb_stall_c0", {63'd0, stall}, 64'd1);
        tick();
        chk("ldsb_req", {63'd0, dmem_req}, 64'd1);
        chk("ldsb_size", {62'd0, dmem_size}, 64'd0);
        chk("ldsb_we", {63'd0, dmem_we}, 64'd0);
        chk("ldsb_addr", dmem_addr, 64'h1003);
        chk("ldsb_stall_c1", {63'd0, stall}, 64'd1);
        tick();
        chk("ldsb_stall_c2", {63'd0, stall}, 64'd1);
        chk("ldsb_req_held", {63'd0, dmem_req}, 64'd1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 64'h80;
        #1;
        chk("ldsb_stall_ack", {63'd0, stall}, 64'd0);
        sb.push_back(rec(2'b11, 6'b001001, 64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 1'b0));
        tick();
        chk("ldsb_drained", sb.size(), 64'd0);
        chk("ldsb_req_drop", {63'd0, dmem_req}, 64'd0);
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        idle_in();

        // STX at 0x2000, ack in the first request cycle
        drive(2'b11, 6'b001110, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 5'd9, 1'b1, 1'b1);
        #1;
        chk("stx_stall_c0", {63'd0, stall}, 64'd1);
        tick();
        chk("stx_req", {63'd0, dmem_req}, 64'd1);
        chk("stx_we", {63'd0, dmem_we}, 64'd1);
        chk("stx_size", {62'd0, dmem_size}, 64'd3);
        chk("stx_wdata", dmem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        dmem_ack = 1'b1;
        #1;
        chk("stx_stall_c1", {63'd0, stall}, 64'd0);
        sb.push_back(rec(2'b11, 6'b001110, 64'h2000, 64'd0, 5'd9, 1'b0, 1'b0));
        tick();
        chk("stx_drained", sb.size(), 64'd0);
        chk("stx_req_drop", {63'd0, dmem_req}, 64'd0);
        dmem_ack = 1'b0;
        idle_in();

        // LDUW at 0x1002: misaligned trap
        drive(2'b11, 6'b000000, 64'h1002, 64'd0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("lduw_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("lduw_trap", {63'd0, trap}, 64'd1);
        chk("lduw_noreq", {63'd0, dmem_req}, 64'd0);
        idle_in();
        tick();
        chk("lduw_trap_end", {63'd0, trap}, 64'd0);

        // LDX at 0x3000 abandoned by reset in its second WAIT cycle
        drive(2'b11, 6'b001011, 64'h3000, 64'd0, 5'd4, 1'b1, 1'b1);
        tick();
        chk("ldx_req", {63'd0, dmem_req}, 64'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("ldx_stall_rst", {63'd0, stall}, 64'd0);
        tick();
        chk("ldx_req_drop", {63'd0, dmem_req}, 64'd0);
        reset = 1'b0;
        idle_in();
        dmem_ack = 1'b1; dmem_rdata = 64'h55;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        tick();
        chk("ldx_no_req", {63'd0, dmem_req}, 64'd0);

        // LDUH at 0x10 then ADD, ack in the first request cycle
        drive(2'b11, 6'b000010, 64'h10, 64'd0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("lduh_stall_c0", {63'd0, stall}, 64'd1);
        tick();
        chk("lduh_size", {62'd0, dmem_size}, 64'd1);
        dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_ABCD;
        sb.push_back(rec(2'b11, 6'b000010, 64'h10, 64'h0000_0000_0000_ABCD, 5'd6, 1'b1, 1'b0));
        tick();
        chk("lduh_drained", sb.size(), 64'd0);
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        drive(2'b10, 6'b000000, 64'h77, 64'd0, 5'd8, 1'b1, 1'b0);
        #1;
        chk("add2_stall", {63'd0, stall}, 64'd0);
        sb.push_back(rec(2'b10, 6'b000000, 64'h77, 64'd0, 5'd8, 1'b1, 1'b0));
        tick();
        chk("add2_drained", sb.size(), 64'd0);
        idle_in();
        dmem_ack = 1'b1; dmem_rdata = 64'h99;
        tick();
        chk("idle_ack_req", {63'd0, dmem_req}, 64'd0);
        dmem_ack = 1'b0;
        tick();
        chk("sb_empty", sb.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
